nibble_stream_packer: RTL and testbench

- Sits directly downstream of the 4-bit long (cascaded BRAM) FIFO.
- Pops 4-bit nibbles from the FIFO's first-word-fall-through read port and packs them into OUT_WIDTH-bit words.
- Presents the words on a valid/ready master stream.
- Supports an explicit flush that emits a zero-padded partial word marked last, so variable-length bursts can be drained.

---
 rtl/nibble_stream_pkg.sv | 22 ++
 rtl/nibble_stream_out_reg.sv | 45 ++++
 rtl/nibble_stream_packer.sv | 131 +++++++++++++
 tb/tb_nibble_stream_packer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_stream_pkg.sv
// nibble_stream_pkg: shared types and helpers for the nibble stream packer.
//   state_t        - packer FSM states
//   START_WAIT_MIN - the FIFO masks its read enable for its first 9 cycles
//                    after reset, so the startup wait never goes below this
//   nib_slot()     - bit offset of nibble slot idx within an output word
package nibble_stream_pkg;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        RUN        = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    localparam int START_WAIT_MIN = 9;

    // Slot 0 is the first nibble popped: bottom of the word when lsb_first,
    // otherwise the top nibble.
    function automatic int nib_slot(input int idx, input int out_width, input bit lsb_first);
        return lsb_first ? (4 * idx) : (out_width - 4 - 4 * idx);
    endfunction

endpackage

// File: rtl/nibble_stream_out_reg.sv
// nibble_stream_out_reg: one-entry output register for the valid/ready
// master stream.
//   load        - capture ld_* into the register (only asserted when out_free)
//   ld_data/ld_last/ld_nibbles - word payload to capture
//   m_tready    - sink ready
//   m_tvalid/m_tdata/m_tlast/m_tnibbles - registered stream outputs
//   out_free    - register empty or being drained this cycle
module nibble_stream_out_reg #(
    parameter int OUT_WIDTH = 16,
    parameter int CW        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [OUT_WIDTH-1:0] ld_data,
    input  logic                 ld_last,
    input  logic [CW-1:0]        ld_nibbles,
    input  logic                 m_tready,
    output logic                 m_tvalid,
    output logic [OUT_WIDTH-1:0] m_tdata,
    output logic                 m_tlast,
    output logic [CW-1:0]        m_tnibbles,
    output logic                 out_free
);

    assign out_free = !m_tvalid || m_tready;

    // Payload only changes on load, so it stays stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tlast    <= 1'b0;
            m_tnibbles <= '0;
        end else if (load) begin
            m_tvalid   <= 1'b1;
            m_tdata    <= ld_data;
            m_tlast    <= ld_last;
            m_tnibbles <= ld_nibbles;
        end else if (m_tready) begin
            m_tvalid   <= 1'b0;
        end
    end

endmodule

// File: rtl/nibble_stream_packer.sv
// nibble_stream_packer: pops 4-bit nibbles from a FWFT FIFO and packs them
// into OUT_WIDTH-bit words on a valid/ready stream. A flush pulse emits the
// partial word zero-padded with m_tlast=1.
//   clk, rst            - clock, synchronous active-high reset
//   fifo_dout/empty     - FWFT FIFO read side; fifo_rd_en pops
//   flush, flush_done   - flush request / completion pulse
//   m_tdata/tvalid/tready/tlast/tnibbles - output stream
// OUT_WIDTH must be a multiple of 4 and at least 8.
module nibble_stream_packer
    import nibble_stream_pkg::*;
#(
    parameter int OUT_WIDTH  = 16,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int START_WAIT = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     fifo_dout,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_en,
    input  logic                           flush,
    output logic                           flush_done,
    output logic [OUT_WIDTH-1:0]           m_tdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic                           m_tlast,
    output logic [$clog2(OUT_WIDTH/4+1)-1:0] m_tnibbles
);

    localparam int NIB = OUT_WIDTH / 4;
    localparam int CW  = $clog2(NIB + 1);
    // Never release reads before the FIFO unmasks its read enable.
    localparam int WAIT_CYC = (START_WAIT < START_WAIT_MIN) ? START_WAIT_MIN : START_WAIT;
    localparam int WW  = $clog2(WAIT_CYC + 1);
    localparam logic [CW-1:0] NIB_C     = CW'(NIB);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);

    state_t               state, state_nxt;
    logic [WW-1:0]        wcnt, wcnt_nxt;
    logic                 pend, pend_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [OUT_WIDTH-1:0] acc, acc_nxt;
    logic                 out_free, xfer, flush_load, rd_en, load;
    logic [CW-1:0]        wr_slot;

    assign xfer       = (state == RUN) && (cnt == NIB_C) && out_free;
    assign flush_load = (state == FLUSH) && (cnt != '0) && out_free;
    assign load       = xfer || flush_load;
    assign rd_en      = !rst && (state == RUN) && !flush && !fifo_empty
                        && ((cnt < NIB_C) || xfer);
    assign fifo_rd_en = rd_en;
    assign flush_done = !rst && (state == FLUSH) && ((cnt == '0) || out_free);
    // A word leaving this cycle frees the accumulator, so the new nibble starts it.
    assign wr_slot    = xfer ? '0 : cnt;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        pend_nxt  = pend;
        case (state)
            WAIT_START: begin
                if (flush) pend_nxt = 1'b1;
                if (wcnt == WAIT_LAST) state_nxt = RUN;
                else                   wcnt_nxt  = wcnt + WW'(1);
            end
            RUN: begin
                if (flush || pend) begin
                    state_nxt = FLUSH;
                    pend_nxt  = 1'b0;
                end
            end
            FLUSH: begin
                // flush requests while already flushing are dropped
                if (flush_done) state_nxt = RUN;
            end
            default: state_nxt = WAIT_START;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (flush_load)  cnt_nxt = '0;
        else if (xfer)   cnt_nxt = rd_en ? CW'(1) : '0;
        else if (rd_en)  cnt_nxt = cnt + CW'(1);
    end

    // Clear after each emitted word so a later flush pads unused slots with 0.
    always_comb begin
        acc_nxt = acc;
        if (load) acc_nxt = '0;
        for (int k = 0; k < NIB; k++) begin
            if (rd_en && (wr_slot == CW'(k)))
                acc_nxt[nib_slot(k, OUT_WIDTH, LSB_FIRST) +: 4] = fifo_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_START;
            wcnt  <= '0;
            pend  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            pend  <= pend_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    nibble_stream_out_reg #(
        .OUT_WIDTH (OUT_WIDTH),
        .CW        (CW)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .ld_data    (acc),
        .ld_last    (flush_load),
        .ld_nibbles (flush_load ? cnt : NIB_C),
        .m_tready   (m_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tnibbles (m_tnibbles),
        .out_free   (out_free)
    );

endmodule

// File: tb/tb_nibble_stream_packer.sv
// Directed bench for nibble_stream_packer. Two instances share one FIFO
// model and stimulus: dut (LSB_FIRST=1) and dut_m (LSB_FIRST=0); their
// control behaviour is data independent, so they run in lockstep.
module tb_nibble_stream_packer;

    typedef struct packed {
        logic        last;
        logic [2:0]  nib;
        logic [15:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fifo_dout  = 4'h0;
    logic        fifo_empty = 1'b1;
    logic        flush;
    logic        m_tready;
    logic        fifo_rd_en, flush_done, m_tvalid, m_tlast;
    logic [15:0] m_tdata;
    logic [2:0]  m_tnibbles;
    logic        fifo_rd_en_m, flush_done_m, m_tvalid_m, m_tlast_m;
    logic [15:0] m_tdata_m;
    logic [2:0]  m_tnibbles_m;

    logic [3:0]  q[$];
    word_t       w_q[$];
    logic [15:0] wm_q[$];
    int          pop_cnt = 0;
    int          fd_cnt  = 0;
    int          checks  = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    nibble_stream_packer #(.OUT_WIDTH(16), .LSB_FIRST(1'b1), .START_WAIT(16)) dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .flush_done(flush_done),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tnibbles(m_tnibbles)
    );

    nibble_stream_packer #(.OUT_WIDTH(16), .LSB_FIRST(1'b0), .START_WAIT(16)) dut_m (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en_m), .flush(flush), .flush_done(flush_done_m),
        .m_tdata(m_tdata_m), .m_tvalid(m_tvalid_m), .m_tready(m_tready),
        .m_tlast(m_tlast_m), .m_tnibbles(m_tnibbles_m)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // FWFT FIFO model: a pop decided before the edge takes effect after it.
    always begin : fifo_model
        logic p;
        @(negedge clk);
        p = fifo_rd_en;
        @(posedge clk);
        #1;
        if (p && q.size() > 0) begin
            void'(q.pop_front());
            pop_cnt++;
        end
        #1;
        fifo_empty = (q.size() == 0);
        fifo_dout  = fifo_empty ? 4'h0 : q[0];
    end

    // Handshakes and flush_done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (m_tvalid && m_tready)   w_q.push_back({m_tlast, m_tnibbles, m_tdata});
        if (m_tvalid_m && m_tready) wm_q.push_back(m_tdata_m);
        if (flush_done) fd_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] v);
        q.push_back(v);
    endtask

    task automatic expect_word(input string tag, input logic [15:0] d, input logic l,
                               input logic [2:0] nb, input logic [15:0] dm);
        word_t       w;
        logic [15:0] m;
        if (w_q.size() == 0 || wm_q.size() == 0) begin
            chk({tag, "_present"}, 32'd0, 32'd1);
            return;
        end
        w = w_q.pop_front();
        m = wm_q.pop_front();
        chk({tag, "_data"}, 32'(w.data), 32'(d));
        chk({tag, "_last"}, 32'(w.last), 32'(l));
        chk({tag, "_nib"},  32'(w.nib),  32'(nb));
        chk({tag, "_msb"},  32'(m),      32'(dm));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int p0;
        int f0;
        rst = 1'b1;
        flush = 1'b0;
        m_tready = 1'b1;
        step(3);

        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_rden",   32'(fifo_rd_en), 32'd0);
        chk("rst_tdata",  32'(m_tdata), 32'd0);
        chk("rst_fdone",  32'(flush_done), 32'd0);
        for (int i = 1; i <= 8; i++) push(4'(i));

        // startup wait
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("post_rst_tnib",   32'(m_tnibbles), 32'd0);
        chk("post_rst_tlast",  32'(m_tlast), 32'd0);
        n = 0;
        while (!fifo_rd_en && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("start_wait", 32'(n), 32'd16);

        // packing: eight back-to-back pops
        n = 0;
        while (fifo_rd_en && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("rd_run_len", 32'(n), 32'd8);
        step(6);
        chk("pack_words", 32'(w_q.size()), 32'd2);
        expect_word("pack0", 16'h4321, 1'b0, 3'd4, 16'h1234);
        expect_word("pack1", 16'h8765, 1'b0, 3'd4, 16'h5678);

        // backpressure
        m_tready = 1'b0;
        p0 = pop_cnt;
        for (int i = 1; i <= 12; i++) push(4'(i));
        step(20);
        chk("bp_pops", 32'(pop_cnt - p0), 32'd8);
        @(negedge clk);
        chk("bp_rden",   32'(fifo_rd_en), 32'd0);
        chk("bp_tvalid", 32'(m_tvalid), 32'd1);
        chk("bp_hold",   32'(m_tdata), 32'h4321);
        chk("bp_hold_m", 32'(m_tdata_m), 32'h1234);
        step(1);
        m_tready = 1'b1;
        step(12);
        chk("bp_pops_all", 32'(pop_cnt - p0), 32'd12);
        chk("bp_words", 32'(w_q.size()), 32'd3);
        expect_word("bp0", 16'h4321, 1'b0, 3'd4, 16'h1234);
        expect_word("bp1", 16'h8765, 1'b0, 3'd4, 16'h5678);
        expect_word("bp2", 16'hCBA9, 1'b0, 3'd4, 16'h9ABC);

        // flush of a 3-nibble partial word
        push(4'hA); push(4'hB); push(4'hC);
        step(6);
        f0 = fd_cnt;
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(5);
        chk("fl_done", 32'(fd_cnt - f0), 32'd1);
        chk("fl_words", 32'(w_q.size()), 32'd1);
        expect_word("fl", 16'h0CBA, 1'b1, 3'd3, 16'hABC0);

        // flush with nothing held, arriving with a nibble ready to pop
        f0 = fd_cnt;
        p0 = pop_cnt;
        flush = 1'b1;
        push(4'hE);
        @(negedge clk);
        chk("fl_supp_rden", 32'(fifo_rd_en), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        step(5);
        chk("fl0_done",  32'(fd_cnt - f0), 32'd1);
        chk("fl0_words", 32'(w_q.size()), 32'd0);
        chk("fl0_pops",  32'(pop_cnt - p0), 32'd1);

        // reset with nibbles held
        push(4'h1); push(4'h2);
        step(4);
        rst = 1'b1;
        q.delete();
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_tvalid", 32'(m_tvalid), 32'd0);
        chk("mr_tnib",   32'(m_tnibbles), 32'd0);
        push(4'h5); push(4'h6); push(4'h7); push(4'h8);
        step(30);
        chk("mr_words", 32'(w_q.size()), 32'd1);
        expect_word("mr", 16'h8765, 1'b0, 3'd4, 16'h5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
